// File: rtl/dm_arbiter_pkg.sv
// rtl/dm_arbiter_pkg.sv - shared types and constants for the data-memory arbiter
package dm_arbiter_pkg;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    typedef logic req_id_t;

    localparam req_id_t ID_CPU = 1'b0;
    localparam req_id_t ID_AUX = 1'b1;

endpackage

// File: rtl/dm_arbiter_if.sv
// rtl/dm_arbiter_if.sv - requester, memory and status signals of the data-memory arbiter
interface dm_arbiter_if
    import dm_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              c_req;
    logic              c_we;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic              c_ack;
    logic [DATA_W-1:0] c_rdata;

    logic              a_req;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_ack;
    logic [DATA_W-1:0] a_rdata;

    logic [ADDR_W-1:0] mem_a;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_read;
    logic              mem_write;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    // Environment side: requesters and the memory.
    modport master (
        output c_req, c_we, c_addr, c_wdata,
        input  c_ack, c_rdata,
        output a_req, a_we, a_addr, a_wdata,
        input  a_ack, a_rdata,
        input  mem_a, mem_wdata, mem_read, mem_write,
        output mem_rdata,
        input  busy
    );

    // Arbiter side.
    modport slave (
        input  c_req, c_we, c_addr, c_wdata,
        output c_ack, c_rdata,
        input  a_req, a_we, a_addr, a_wdata,
        output a_ack, a_rdata,
        output mem_a, mem_wdata, mem_read, mem_write,
        input  mem_rdata,
        output busy
    );

endinterface

// File: rtl/dm_arb_pick.sv
// rtl/dm_arb_pick.sv - combinational winner select; DM_ARB_CPU_PRIORITY_EN gives CPU fixed priority on ties
module dm_arb_pick
    import dm_arbiter_pkg::*;
(
    input  logic [1:0] req_i,
    input  req_id_t    last_grant_i,
    input  logic [1:0] excl_i,
    output logic       valid_o,
    output req_id_t    id_o
);

    logic [1:0] eff;

    always_comb begin
        eff     = req_i & ~excl_i;
        valid_o = |eff;
        if (&eff) begin
`ifdef DM_ARB_CPU_PRIORITY_EN
            id_o = ID_CPU;
`else
            id_o = ~last_grant_i;
`endif
        end else begin
            id_o = eff[1] ? ID_AUX : ID_CPU;
        end
    end

endmodule

// File: rtl/dm_arbiter.sv
// rtl/dm_arbiter.sv - two-port arbiter (CPU/AUX) onto one data memory; DM_ARB_CPU_PRIORITY_EN selects fixed priority
module dm_arbiter
    import dm_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic         clk,
    input  logic         reset,
    dm_arbiter_if.slave  bus
);

    state_e            state_q, state_d;
    req_id_t           win_q;
    req_id_t           last_grant_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] c_rdata_q;
    logic [DATA_W-1:0] a_rdata_q;

    logic [1:0]        excl;
    logic              pick_valid;
    req_id_t           pick_id;
    logic              grant_en;

    // In DONE only the requester just served is masked out, so the other one gets a turn.
    assign excl = (state_q == DONE) ? ((win_q == ID_CPU) ? 2'b01 : 2'b10) : 2'b00;

    dm_arb_pick u_pick (
        .req_i        ({bus.a_req, bus.c_req}),
        .last_grant_i (last_grant_q),
        .excl_i       (excl),
        .valid_o      (pick_valid),
        .id_o         (pick_id)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_en = 1'b0;
        case (state_q)
            IDLE: begin
                grant_en = pick_valid;
                state_d  = pick_valid ? ACCESS : IDLE;
            end
            ACCESS: begin
                state_d = DONE;
            end
            DONE: begin
                grant_en = pick_valid;
                state_d  = pick_valid ? ACCESS : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.c_ack     = 1'b0;
        bus.a_ack     = 1'b0;
        bus.busy      = (state_q != IDLE);
        case (state_q)
            ACCESS: begin
                bus.mem_read  = ~we_q;
                bus.mem_write = we_q;
            end
            DONE: begin
                bus.c_ack = (win_q == ID_CPU);
                bus.a_ack = (win_q == ID_AUX);
            end
            default: begin
            end
        endcase
    end

    // Latched request fields are the only source for the memory side, so requester glitches after grant are ignored.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            win_q        <= ID_CPU;
            last_grant_q <= ID_AUX;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            c_rdata_q    <= '0;
            a_rdata_q    <= '0;
        end else begin
            if (grant_en) begin
                win_q <= pick_id;
                if (pick_id == ID_AUX) begin
                    we_q    <= bus.a_we;
                    addr_q  <= bus.a_addr;
                    wdata_q <= bus.a_wdata;
                end else begin
                    we_q    <= bus.c_we;
                    addr_q  <= bus.c_addr;
                    wdata_q <= bus.c_wdata;
                end
            end
            if (state_q == ACCESS) begin
                last_grant_q <= win_q;
                if (win_q == ID_CPU) begin
                    c_rdata_q <= we_q ? '0 : bus.mem_rdata;
                end else begin
                    a_rdata_q <= we_q ? '0 : bus.mem_rdata;
                end
            end
        end
    end

    assign bus.mem_a     = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.c_rdata   = c_rdata_q;
    assign bus.a_rdata   = a_rdata_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// tb/tb_dm_arbiter.sv - scoreboard bench for dm_arbiter with a behavioural memory
module tb_dm_arbiter;

    logic clk;
    logic reset;

    int vectors;
    int miscompares;

    logic [31:0] mem [0:1023];
    logic [31:0] cq [$];
    logic [31:0] aq [$];
    bit          ord_q [$];

    dm_arbiter_if #(.ADDR_W(10), .DATA_W(32)) bus ();

    dm_arbiter #(.ADDR_W(10), .DATA_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.mem_rdata = mem[bus.mem_a];

    always @(posedge clk) begin
        if (bus.mem_write) mem[bus.mem_a] <= bus.mem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.mem_read || bus.mem_write) chk("strobe_excl", 32'(bus.mem_read & bus.mem_write), 32'd0);
        if (bus.c_ack || bus.a_ack) chk("dual_ack", 32'(bus.c_ack & bus.a_ack), 32'd0);
        if (bus.c_ack) begin
            if (cq.size() == 0) chk("c_unexpected_ack", 32'd1, 32'd0);
            else chk("c_rdata", bus.c_rdata, cq.pop_front());
            if (ord_q.size() != 0) chk("grant_order", 32'd0, 32'(ord_q.pop_front()));
        end
        if (bus.a_ack) begin
            if (aq.size() == 0) chk("a_unexpected_ack", 32'd1, 32'd0);
            else chk("a_rdata", bus.a_rdata, aq.pop_front());
            if (ord_q.size() != 0) chk("grant_order", 32'd1, 32'(ord_q.pop_front()));
        end
    end

    task automatic wait_ack(input bit port);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (port ? bus.a_ack : bus.c_ack) return;
        end
        chk(port ? "a_ack_timeout" : "c_ack_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
        mem[5]  = 32'hDEAD_BEEF;
        mem[20] = 32'h0BAD_F00D;
        mem[21] = 32'hCAFE_0021;
        mem[31] = 32'h1357_9BDF;
        reset       = 1'b0;
        bus.c_req   = 1'b0; bus.c_we = 1'b0; bus.c_addr = '0; bus.c_wdata = '0;
        bus.a_req   = 1'b0; bus.a_we = 1'b0; bus.a_addr = '0; bus.a_wdata = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy",      32'(bus.busy),      32'd0);
        chk("rst_mem_read",  32'(bus.mem_read),  32'd0);
        chk("rst_mem_write", 32'(bus.mem_write), 32'd0);
        chk("rst_c_ack",     32'(bus.c_ack),     32'd0);
        chk("rst_a_ack",     32'(bus.a_ack),     32'd0);
        chk("rst_mem_a",     32'(bus.mem_a),     32'd0);
        chk("rst_mem_wdata", bus.mem_wdata,      32'd0);
        chk("rst_c_rdata",   bus.c_rdata,        32'd0);
        chk("rst_a_rdata",   bus.a_rdata,        32'd0);
        reset = 1'b1;

        // CPU read alone
        @(negedge clk);
        bus.c_we = 1'b0; bus.c_addr = 10'd5; bus.c_req = 1'b1;
        cq.push_back(32'hDEAD_BEEF);
        @(negedge clk);
        chk("rd_access_read",  32'(bus.mem_read),  32'd1);
        chk("rd_access_write", 32'(bus.mem_write), 32'd0);
        chk("rd_access_addr",  32'(bus.mem_a),     32'd5);
        chk("rd_access_busy",  32'(bus.busy),      32'd1);
        @(negedge clk);
        chk("rd_done_c_ack", 32'(bus.c_ack), 32'd1);
        chk("rd_done_a_ack", 32'(bus.a_ack), 32'd0);
        bus.c_req = 1'b0;
        @(negedge clk);
        chk("rd_after_ack",  32'(bus.c_ack),    32'd0);
        chk("rd_after_read", 32'(bus.mem_read), 32'd0);
        chk("rd_after_busy", 32'(bus.busy),     32'd0);
        chk("rd_a_rdata_hold", bus.a_rdata,     32'd0);

        // AUX write to the top word
        bus.a_we = 1'b1; bus.a_addr = 10'h3FF; bus.a_wdata = 32'h1234_5678; bus.a_req = 1'b1;
        aq.push_back(32'd0);
        @(negedge clk);
        chk("wr_access_write", 32'(bus.mem_write), 32'd1);
        chk("wr_access_read",  32'(bus.mem_read),  32'd0);
        chk("wr_access_addr",  32'(bus.mem_a),     32'h3FF);
        chk("wr_access_wdata", bus.mem_wdata,      32'h1234_5678);
        @(negedge clk);
        chk("wr_done_a_ack", 32'(bus.a_ack), 32'd1);
        chk("wr_done_c_ack", 32'(bus.c_ack), 32'd0);
        chk("wr_done_write", 32'(bus.mem_write), 32'd0);
        bus.a_req = 1'b0;
        @(negedge clk);
        chk("wr_mem_word",     mem[10'h3FF], 32'h1234_5678);
        chk("wr_c_rdata_hold", bus.c_rdata,  32'hDEAD_BEEF);

        // Tie after reset: CPU first, AUX access straight from DONE
        do_reset();
        bus.c_we = 1'b0; bus.c_addr = 10'd20; bus.c_req = 1'b1;
        bus.a_we = 1'b0; bus.a_addr = 10'd21; bus.a_req = 1'b1;
        cq.push_back(32'h0BAD_F00D);
        aq.push_back(32'hCAFE_0021);
        ord_q.push_back(1'b0);
        ord_q.push_back(1'b1);
        @(negedge clk);
        chk("tie_first_addr", 32'(bus.mem_a),    32'd20);
        chk("tie_first_read", 32'(bus.mem_read), 32'd1);
        @(negedge clk);
        chk("tie_c_ack", 32'(bus.c_ack), 32'd1);
        bus.c_req = 1'b0;
        @(negedge clk);
        chk("tie_second_read", 32'(bus.mem_read), 32'd1);
        chk("tie_second_addr", 32'(bus.mem_a),    32'd21);
        chk("tie_no_idle",     32'(bus.busy),     32'd1);
        @(negedge clk);
        chk("tie_a_ack", 32'(bus.a_ack), 32'd1);
        bus.a_req = 1'b0;
        @(negedge clk);
        chk("tie_end_busy", 32'(bus.busy), 32'd0);

        // Both hold requests: six alternating grants
        do_reset();
        bus.c_we = 1'b1; bus.c_addr = 10'd30; bus.c_wdata = 32'h0000_00C3; bus.c_req = 1'b1;
        bus.a_we = 1'b0; bus.a_addr = 10'd31; bus.a_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cq.push_back(32'd0);
            aq.push_back(32'h1357_9BDF);
            ord_q.push_back(1'b0);
            ord_q.push_back(1'b1);
        end
        fork
            begin
                for (int k = 0; k < 3; k++) wait_ack(1'b0);
                bus.c_req = 1'b0;
            end
            begin
                for (int k = 0; k < 3; k++) wait_ack(1'b1);
                bus.a_req = 1'b0;
            end
        join
        @(negedge clk);
        chk("rr_c_queue_left",   32'(cq.size()),    32'd0);
        chk("rr_a_queue_left",   32'(aq.size()),    32'd0);
        chk("rr_order_left",     32'(ord_q.size()), 32'd0);
        chk("rr_mem_word",       mem[30],           32'h0000_00C3);
        chk("rr_end_busy",       32'(bus.busy),     32'd0);

        // Reset asserted mid-ACCESS of a write
        bus.c_we = 1'b1; bus.c_addr = 10'd40; bus.c_wdata = 32'hAAAA_5555; bus.c_req = 1'b1;
        @(negedge clk);
        chk("rst_mid_write_pre", 32'(bus.mem_write), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("rst_mid_write_drop", 32'(bus.mem_write), 32'd0);
        chk("rst_mid_busy_drop",  32'(bus.busy),      32'd0);
        bus.c_req = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_mid_after_busy", 32'(bus.busy),  32'd0);
        chk("rst_mid_after_ack",  32'(bus.c_ack), 32'd0);
        chk("rst_mid_mem_word",   mem[40],        32'd0);
        chk("rst_mid_c_queue",    32'(cq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
